send_arb: RTL and testbench
===========================

SEND_ARB -- requirements
Module: send_arb

Interface
REQ-001 Parameter NPU, 4: number of PUs sharing the outbound link (fixed at 4; 2-bit PU index).
REQ-002 Parameter DW, 16: data-memory word and link data width.
REQ-003 Parameter AW, 8: data-memory address and transfer-size width.
REQ-004 Parameter PW, 4: destination port width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req  in  NPU  per-PU SEND request, level held while the PU's SEND instruction is stalled.
REQ-008 req_addr  in  NPU*AW  per-PU start address (the value of ra); PU i in bits [i*AW +: AW].
REQ-009 req_size  in  NPU*AW  per-PU word count (the value of rb).
REQ-010 req_port  in  NPU*PW  per-PU destination port (the 4-bit immediate).
REQ-011 busy  out  NPU  PU stall: busy[i] = req[i] & ~done[i].
REQ-012 done  out  NPU  one-cycle completion pulse for the granted PU.
REQ-013 dm_re  out  1  data-memory read strobe.
REQ-014 dm_sel  out  2  index of the PU whose data memory is read.
REQ-015 dm_addr  out  AW  read address.
REQ-016 dm_rdata  in  DW  read data, valid exactly one cycle after dm_re.
REQ-017 tx_valid, tx_data[DW], tx_port[PW], tx_src[2], tx_last  out  link word and sideband.
REQ-018 tx_ready  in  1  link accepts the word when tx_valid & tx_ready.

Function
REQ-019 The FSM SHALL use the states IDLE, READ, XMIT and DONE.
REQ-020 IDLE: if any req is high, the arbiter SHALL pick a winner round-robin, starting the search at ptr, and latch its addr, size, port and index.
REQ-021 After a grant, the FSM SHALL go to DONE when the latched size is 0, otherwise to READ.
REQ-022 READ: dm_re=1, dm_sel=winner, dm_addr=cur_addr for exactly one cycle, then go to XMIT.
REQ-023 XMIT entry SHALL register dm_rdata into tx_data.
REQ-024 In XMIT, tx_valid SHALL stay high, with tx_data/tx_port/tx_src/tx_last stable, until tx_ready is sampled high.
REQ-025 On an XMIT handshake with remaining>1: decrement remaining, cur_addr += 1 (modulo 2^AW, wraps 0xFF->0x00), go to READ.
REQ-026 On an XMIT handshake with remaining==1, the FSM SHALL go to DONE.
REQ-027 tx_last SHALL be 1 only on the word sent when remaining==1.
REQ-028 DONE SHALL last exactly one cycle: done[winner]=1, ptr=winner+1 (mod 4), then IDLE.
REQ-029 req SHALL be evaluated only in IDLE, so a PU whose SEND retires at the DONE edge is never re-granted on a stale request.
REQ-030 Changes to req_* of a granted PU after the grant SHALL have no effect on the transfer in flight.
REQ-031 Timing: req in cycle 0 -> dm_re in cycle 1 -> tx_valid in cycle 2 (with tx_ready=1).
REQ-032 Throughput SHALL be 1 word per 2 cycles; done SHALL pulse 2*size+1 cycles after the grant, or in cycle 1 for size 0.
REQ-033 A request not granted SHALL stay pending with busy high; with all 4 requesting, each PU SHALL be served within 3 intervening transfers.
REQ-034 Outside READ, dm_re SHALL be 0; outside XMIT, tx_valid SHALL be 0; outside DONE, done SHALL be 0.

Reset
REQ-035 On rst assertion, asynchronously: state=IDLE, ptr=0, remaining=0, cur_addr=0, winner=0.
REQ-036 On rst assertion, asynchronously: dm_re=0, dm_sel=0, dm_addr=0, tx_valid=0, tx_data=0, tx_port=0, tx_src=0, tx_last=0, done=0.
REQ-037 Reset mid-transfer SHALL abort the transfer with no done pulse; the PU keeps req high and is re-granted from the start after reset release.

Structure
REQ-038 The state enum, NPU/DW/AW/PW constants and port-width macros SHALL live in the shared PU package/header alongside the existing op and liop codes.
REQ-039 Round-robin selection SHALL be one sub-module, rr_pick: inputs req[4] and ptr[2]; outputs gnt_valid and gnt_idx[2]; purely combinational.

Verification
REQ-040 PU1 req, addr=0x10, size=3, port=5, tx_ready=1 -> dm_addr 0x10/0x11/0x12 in cycles 1/3/5; three tx words, tx_port=5, tx_src=1, tx_last on the third; done[1] in cycle 7.
REQ-041 size=0 from PU2 -> no dm_re and no tx_valid; done[2] in cycle 1; busy[2] low in that cycle.
REQ-042 All four req high at reset release, size=1 each -> grant order 0,1,2,3; then with PU0 re-requesting, PU0 is next.
REQ-043 addr=0xFE, size=3, with tx_ready held low 4 cycles on word 2 -> addresses 0xFE,0xFF,0x00; tx_data stable while stalled; exactly 3 handshakes.
REQ-044 rst pulsed during XMIT of word 2 of 4 -> all outputs zero immediately, no done; after release the same request restarts at the original addr.

Source files
------------

// File: rtl/send_arb_pkg.sv
// Shared constants and types for the outbound SEND arbiter and its round-robin picker.
package send_arb_pkg;

    localparam int NPU_DEF = 4;
    localparam int DW_DEF  = 16;
    localparam int AW_DEF  = 8;
    localparam int PW_DEF  = 4;
    localparam int IW      = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        XMIT,
        DONE
    } state_t;

    function automatic logic [NPU_DEF-1:0] pu_onehot(input logic [IW-1:0] idx);
        return NPU_DEF'(1) << idx;
    endfunction

endpackage

// File: rtl/send_arb_rr_pick.sv
// Combinational round-robin picker: first requester found scanning upward from ptr.
module rr_pick
    import send_arb_pkg::*;
(
    input  logic [NPU_DEF-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               gnt_valid,
    output logic [IW-1:0]      gnt_idx
);

    // Scan from the far end down so the candidate closest to ptr is written last and wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        for (int k = NPU_DEF - 1; k >= 0; k--) begin
            if (req[ptr + IW'(k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = ptr + IW'(k);
            end
        end
    end

endmodule

// File: rtl/send_arb.sv
// Arbitrates PU SEND requests onto one outbound link: reads each word from the
// winner's data memory and streams it out with port/source/last sideband.
//
// state | meaning
// IDLE  | waiting for any req; picks a winner round-robin and latches its request
// READ  | one-cycle data-memory read of the current word
// XMIT  | word held on the link until tx_ready
// DONE  | one-cycle done pulse to the winner, advance round-robin pointer
module send_arb
    import send_arb_pkg::*;
#(
    parameter int NPU = NPU_DEF,
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int PW  = PW_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [NPU-1:0]    req,
    input  logic [NPU*AW-1:0] req_addr,
    input  logic [NPU*AW-1:0] req_size,
    input  logic [NPU*PW-1:0] req_port,
    output logic [NPU-1:0]    busy,
    output logic [NPU-1:0]    done,
    output logic              dm_re,
    output logic [IW-1:0]     dm_sel,
    output logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_rdata,
    output logic              tx_valid,
    output logic [DW-1:0]     tx_data,
    output logic [PW-1:0]     tx_port,
    output logic [IW-1:0]     tx_src,
    output logic              tx_last,
    input  logic              tx_ready
);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [AW-1:0]   remaining;
    logic [AW-1:0]   cur_addr;

    logic            gnt_valid;
    logic [IW-1:0]   gnt_idx;
    logic [AW-1:0]   g_addr;
    logic [AW-1:0]   g_size;
    logic [PW-1:0]   g_port;

    rr_pick u_rr_pick (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign g_addr = req_addr[int'(gnt_idx)*AW +: AW];
    assign g_size = req_size[int'(gnt_idx)*AW +: AW];
    assign g_port = req_port[int'(gnt_idx)*PW +: PW];

    assign busy = req & ~done;

    // req is only looked at in IDLE, so the PU retiring in DONE cannot be re-granted on a stale level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            remaining <= '0;
            cur_addr  <= '0;
            dm_re     <= 1'b0;
            dm_sel    <= '0;
            dm_addr   <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            tx_port   <= '0;
            tx_src    <= '0;
            tx_last   <= 1'b0;
            done      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        winner    <= gnt_idx;
                        cur_addr  <= g_addr;
                        remaining <= g_size;
                        tx_port   <= g_port;
                        tx_src    <= gnt_idx;
                        if (g_size == '0) begin
                            done  <= pu_onehot(gnt_idx);
                            state <= DONE;
                        end else begin
                            dm_re   <= 1'b1;
                            dm_sel  <= gnt_idx;
                            dm_addr <= g_addr;
                            state   <= READ;
                        end
                    end
                end
                READ: begin
                    dm_re    <= 1'b0;
                    tx_valid <= 1'b1;
                    tx_data  <= dm_rdata;
                    tx_last  <= (remaining == AW'(1));
                    state    <= XMIT;
                end
                XMIT: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_last  <= 1'b0;
                        if (remaining == AW'(1)) begin
                            done  <= pu_onehot(winner);
                            state <= DONE;
                        end else begin
                            remaining <= remaining - AW'(1);
                            cur_addr  <= cur_addr + AW'(1);
                            dm_re     <= 1'b1;
                            dm_sel    <= winner;
                            dm_addr   <= cur_addr + AW'(1);
                            state     <= READ;
                        end
                    end
                end
                DONE: begin
                    done  <= '0;
                    ptr   <= winner + IW'(1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_send_arb.sv
// Directed self-checking bench for send_arb; data memory returns {sel, addr} for the word read.
module tb_send_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [31:0] req_size;
    logic [15:0] req_port;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic        dm_re;
    logic [1:0]  dm_sel;
    logic [7:0]  dm_addr;
    logic [15:0] dm_rdata;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic [3:0]  tx_port;
    logic [1:0]  tx_src;
    logic        tx_last;
    logic        tx_ready;

    int total  = 0;
    int passed = 0;

    send_arb dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_size (req_size),
        .req_port (req_port),
        .busy     (busy),
        .done     (done),
        .dm_re    (dm_re),
        .dm_sel   (dm_sel),
        .dm_addr  (dm_addr),
        .dm_rdata (dm_rdata),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_port  (tx_port),
        .tx_src   (tx_src),
        .tx_last  (tx_last),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    assign dm_rdata = dm_re ? {6'd0, dm_sel, dm_addr} : 16'hdead;

    task automatic set_pu(input int i, input logic [7:0] a, input logic [7:0] s, input logic [3:0] p);
        req_addr[i*8 +: 8] = a;
        req_size[i*8 +: 8] = s;
        req_port[i*4 +: 4] = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_addr = '0; req_size = '0; req_port = '0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({dm_re, dm_sel, dm_addr, tx_valid, tx_data, tx_port, tx_src, tx_last, done, busy} !== '0)
            $display("FAIL reset_outputs: got %h required 0",
                     {dm_re, dm_sel, dm_addr, tx_valid, tx_data, tx_port, tx_src, tx_last, done, busy});
        else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({dm_re, tx_valid, done} !== 3'b000)
            $display("FAIL reset_idle: got %b required 000", {dm_re, tx_valid, done});
        else passed++;
    endtask

    task automatic test_basic();
        int          re_cyc[$];
        logic [7:0]  addrs[$];
        logic [15:0] words[$];
        logic        lasts[$];
        int          done_cyc = -1;
        int          side_bad = 0;
        int          exp_cyc[3]   = '{1, 3, 5};
        logic [7:0]  exp_addr[3]  = '{8'h10, 8'h11, 8'h12};
        logic [15:0] exp_word[3]  = '{16'h0110, 16'h0111, 16'h0112};
        logic        exp_last[3]  = '{1'b0, 1'b0, 1'b1};
        set_pu(1, 8'h10, 8'd3, 4'd5); tx_ready = 1'b1; req = 4'b0010;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (dm_re) begin re_cyc.push_back(c); addrs.push_back(dm_addr); end
            if (tx_valid) begin
                words.push_back(tx_data); lasts.push_back(tx_last);
                if (tx_port !== 4'd5 || tx_src !== 2'd1) side_bad++;
            end
            if (done[1]) begin if (done_cyc < 0) done_cyc = c; req[1] = 1'b0; end
        end
        total++;
        if (re_cyc.size() != 3 || words.size() != 3)
            $display("FAIL basic_counts: got reads=%0d words=%0d required 3/3", re_cyc.size(), words.size());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= re_cyc.size() || re_cyc[i] != exp_cyc[i] || addrs[i] !== exp_addr[i])
                $display("FAIL basic_read[%0d]: got cycle/addr %0d/%h required %0d/%h", i,
                         (i < re_cyc.size()) ? re_cyc[i] : -1, (i < addrs.size()) ? addrs[i] : 8'hxx,
                         exp_cyc[i], exp_addr[i]);
            else passed++;
            total++;
            if (i >= words.size() || words[i] !== exp_word[i] || lasts[i] !== exp_last[i])
                $display("FAIL basic_word[%0d]: got data/last %h/%b required %h/%b", i,
                         (i < words.size()) ? words[i] : 16'hxxxx, (i < lasts.size()) ? lasts[i] : 1'bx,
                         exp_word[i], exp_last[i]);
            else passed++;
        end
        total++;
        if (side_bad != 0) $display("FAIL basic_sideband: got %0d bad words required 0", side_bad);
        else passed++;
        total++;
        if (done_cyc != 7) $display("FAIL basic_done_cycle: got %0d required 7", done_cyc);
        else passed++;
    endtask

    task automatic test_size_zero();
        int done_cyc = -1;
        int activity = 0;
        logic busy_at_done = 1'b1;
        set_pu(2, 8'h33, 8'd0, 4'd7); req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (dm_re || tx_valid) activity++;
            if (done[2]) begin
                if (done_cyc < 0) begin done_cyc = c; busy_at_done = busy[2]; end
                req[2] = 1'b0;
            end
        end
        total++;
        if (activity != 0) $display("FAIL zero_activity: got %0d read/tx cycles required 0", activity);
        else passed++;
        total++;
        if (done_cyc != 1) $display("FAIL zero_done_cycle: got %0d required 1", done_cyc);
        else passed++;
        total++;
        if (busy_at_done !== 1'b0) $display("FAIL zero_busy: got %b required 0", busy_at_done);
        else passed++;
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_order[6] = '{0, 1, 2, 3, 0, 2};
        int ncyc = 0;
        bit rereq = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) set_pu(i, 8'(i * 32), 8'd1, 4'(i + 8));
        req = 4'b1111; tx_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ncyc++;
        total++;
        if (busy !== 4'b1111 || dm_sel !== 2'd0 || dm_re !== 1'b1)
            $display("FAIL rr_first_grant: got busy=%b sel=%0d re=%b required 1111/0/1", busy, dm_sel, dm_re);
        else passed++;
        while (order.size() < 6 && ncyc < 80) begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < 4; i++) if (done[i]) begin order.push_back(i); req[i] = 1'b0; end
            if (order.size() == 4 && !rereq) begin req[0] = 1'b1; req[2] = 1'b1; rereq = 1; end
        end
        total++;
        if (order.size() != 6) $display("FAIL rr_timeout: got %0d grants required 6", order.size());
        else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= order.size() || order[i] != exp_order[i])
                $display("FAIL rr_order[%0d]: got %0d required %0d", i,
                         (i < order.size()) ? order[i] : -1, exp_order[i]);
            else passed++;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap_stall();
        logic [7:0]  addrs[$];
        logic [15:0] words[$];
        logic        lasts[$];
        logic [15:0] held = '0;
        int hs = 0, stall = 0, unstable = 0, dones = 0;
        logic [7:0]  exp_addr[3] = '{8'hfe, 8'hff, 8'h00};
        logic [15:0] exp_word[3] = '{16'h03fe, 16'h03ff, 16'h0300};
        logic        exp_last[3] = '{1'b0, 1'b0, 1'b1};
        set_pu(3, 8'hfe, 8'd3, 4'd9); tx_ready = 1'b1; req = 4'b1000;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (dm_re) addrs.push_back(dm_addr);
            if (done[3]) begin dones++; req[3] = 1'b0; end
            if (tx_valid) begin
                if (hs == 1 && stall < 4) begin
                    if (stall == 0) held = tx_data;
                    else if (tx_data !== held) unstable++;
                    tx_ready = 1'b0;
                    stall++;
                end else begin
                    if (hs == 1 && tx_data !== held) unstable++;
                    tx_ready = 1'b1;
                    hs++;
                    words.push_back(tx_data);
                    lasts.push_back(tx_last);
                end
            end else tx_ready = 1'b1;
        end
        total++;
        if (hs != 3 || stall != 4) $display("FAIL wrap_handshakes: got hs=%0d stall=%0d required 3/4", hs, stall);
        else passed++;
        total++;
        if (unstable != 0) $display("FAIL wrap_stable: got %0d changes required 0", unstable);
        else passed++;
        total++;
        if (dones != 1) $display("FAIL wrap_done: got %0d pulses required 1", dones);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= addrs.size() || i >= words.size() || addrs[i] !== exp_addr[i] ||
                words[i] !== exp_word[i] || lasts[i] !== exp_last[i])
                $display("FAIL wrap_word[%0d]: got addr/data/last %h/%h/%b required %h/%h/%b", i,
                         (i < addrs.size()) ? addrs[i] : 8'hxx, (i < words.size()) ? words[i] : 16'hxxxx,
                         (i < lasts.size()) ? lasts[i] : 1'bx, exp_addr[i], exp_word[i], exp_last[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_abort();
        int rst_dones = 0, words = 0, dones = 0, ncyc = 0;
        set_pu(0, 8'h40, 8'd4, 4'd2); tx_ready = 1'b1; req = 4'b0001;
        repeat (4) @(negedge clk);
        total++;
        if ({tx_valid, tx_data} !== {1'b1, 16'h0041})
            $display("FAIL abort_word2: got valid/data %b/%h required 1/0041", tx_valid, tx_data);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({dm_re, dm_sel, dm_addr, tx_valid, tx_data, tx_port, tx_src, tx_last, done} !== '0)
            $display("FAIL abort_async_clear: got %h required 0",
                     {dm_re, dm_sel, dm_addr, tx_valid, tx_data, tx_port, tx_src, tx_last, done});
        else passed++;
        total++;
        if (busy !== 4'b0001) $display("FAIL abort_busy: got %b required 0001", busy);
        else passed++;
        repeat (2) begin
            @(negedge clk);
            if (done !== '0) rst_dones++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({dm_re, dm_sel, dm_addr} !== {1'b1, 2'd0, 8'h40})
            $display("FAIL abort_restart: got re/sel/addr %b/%0d/%h required 1/0/40", dm_re, dm_sel, dm_addr);
        else passed++;
        while (dones == 0 && ncyc < 20) begin
            @(negedge clk);
            ncyc++;
            if (tx_valid) words++;
            if (done !== '0) begin dones++; if (done[0]) req[0] = 1'b0; end
        end
        total++;
        if (rst_dones != 0 || dones != 1 || words != 4)
            $display("FAIL abort_complete: got rst_dones=%0d dones=%0d words=%0d required 0/1/4",
                     rst_dones, dones, words);
        else passed++;
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size_zero();
        test_round_robin();
        test_wrap_stall();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
